pipe_cpu_fwd: RTL and testbench

//  Parametrised 5-stage (IF/ID/EX/MEM/WB) pipelined CPU core; executes the config.v instruction set.

---
 rtl/pipe_cpu_fwd.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pipe_cpu_fwd.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cpu_fwd.sv
// 5-stage pipelined core (IF/ID/EX/MEM/WB) with hazard handling; `FORWARDING_EN selects the
// MEM/WB bypass paths, otherwise ID interlocks on EX/MEM producers. ir = {op[4:0], r1, x|r2, val3|r3}.
module pipe_cpu_fwd #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_datain,
  output logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_datain,
  output logic [DATA_W-1:0] d_dataout,
  output logic              d_we,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy
);

  typedef enum logic [4:0] {
    OP_NOP  = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011,
    OP_SLL  = 5'b00100, OP_SLA  = 5'b00101, OP_SRL  = 5'b00110, OP_SRA   = 5'b00111,
    OP_ADD  = 5'b01000, OP_ADDI = 5'b01001, OP_SUB  = 5'b01010, OP_SUBI  = 5'b01011,
    OP_CMP  = 5'b01100, OP_AND  = 5'b01101, OP_OR   = 5'b01110, OP_XOR   = 5'b01111,
    OP_LDIH = 5'b10000, OP_ADDC = 5'b10001, OP_SUBC = 5'b10010,
    OP_JUMP = 5'b11000, OP_JMPR = 5'b11001, OP_BZ   = 5'b11010, OP_BNZ   = 5'b11011,
    OP_BN   = 5'b11100, OP_BNN  = 5'b11101, OP_BC   = 5'b11110, OP_BNC   = 5'b11111
  } op_e;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  function automatic logic writes_rd(input op_e op);
    case (op)
      OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLA, OP_SRL, OP_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic a_from_r1(input op_e op);
    case (op)
      OP_ADDI, OP_SUBI, OP_LDIH, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic has_a(input op_e op);
    case (op)
      OP_NOP, OP_HALT, OP_JUMP: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic b_is_r3(input op_e op);
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic b_is_val3(input op_e op);
    case (op)
      OP_LOAD, OP_STORE, OP_SLL, OP_SLA, OP_SRL, OP_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic sets_flags(input op_e op);
    case (op)
      OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP,
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLA, OP_SRL, OP_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads_reg(input logic [15:0] ir, input logic [2:0] r);
    op_e        op;
    logic [2:0] src_a;
    op    = op_e'(ir[15:11]);
    src_a = a_from_r1(op) ? ir[10:8] : ir[6:4];
    return (has_a(op) && src_a == r) || (b_is_r3(op) && ir[2:0] == r) ||
           (op == OP_STORE && ir[10:8] == r);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         id_ir_q, id_ir_d, ex_ir_q, ex_ir_d, mem_ir_q, mem_ir_d, wb_ir_q, wb_ir_d;
  logic [DATA_W-1:0]   reg_a_q, reg_a_d, reg_b_q, reg_b_d, smdr_q, smdr_d;
  logic [DATA_W-1:0]   reg_c_q, reg_c_d, smdr1_q, smdr1_d, reg_c1_q, reg_c1_d;
  logic                zf_q, zf_d, nf_q, nf_d, cf_q, cf_d;
  logic [DATA_W-1:0]   gr_q [8];

  op_e                 id_op, ex_op, mem_op, wb_op;
  logic [2:0]          id_src_a, ex_src_a, ex_rd, mem_rd, wb_rd;
  logic                run, wb_we, stall, taken;
  logic [DATA_W-1:0]   rd_a, rd_b, rd_s, op_a, op_b, st_data, alu_res;
  logic                alu_cf;
  logic [ADDR_W-1:0]   target;
  logic                unused_ir_bits;

  assign run      = (state_q == S_EXEC) && enable;
  assign id_op    = op_e'(id_ir_q[15:11]);
  assign ex_op    = op_e'(ex_ir_q[15:11]);
  assign mem_op   = op_e'(mem_ir_q[15:11]);
  assign wb_op    = op_e'(wb_ir_q[15:11]);
  assign ex_rd    = ex_ir_q[10:8];
  assign mem_rd   = mem_ir_q[10:8];
  assign wb_rd    = wb_ir_q[10:8];
  assign wb_we    = run && writes_rd(wb_op);
  assign id_src_a = a_from_r1(id_op) ? id_ir_q[10:8] : id_ir_q[6:4];
  assign ex_src_a = a_from_r1(ex_op) ? ex_ir_q[10:8] : ex_ir_q[6:4];
  assign unused_ir_bits = ^{mem_ir_q[7:0], wb_ir_q[7:0]};

  // ID register read: a same-cycle WB write to the register wins
  always_comb begin
    rd_a = gr_q[id_src_a];
    rd_b = gr_q[id_ir_q[2:0]];
    rd_s = gr_q[id_ir_q[10:8]];
    if (wb_we && wb_rd == id_src_a)      rd_a = reg_c1_q;
    if (wb_we && wb_rd == id_ir_q[2:0])  rd_b = reg_c1_q;
    if (wb_we && wb_rd == id_ir_q[10:8]) rd_s = reg_c1_q;
  end

`ifdef FORWARDING_EN
  logic mem_fwd, wb_fwd;
  assign mem_fwd = writes_rd(mem_op) && (mem_op != OP_LOAD);
  assign wb_fwd  = writes_rd(wb_op);
  assign stall   = (ex_op == OP_LOAD) && reads_reg(id_ir_q, ex_rd);

  // WB applied first so the younger MEM result overrides it
  always_comb begin
    op_a    = reg_a_q;
    op_b    = reg_b_q;
    st_data = smdr_q;
    if (wb_fwd && wb_rd == ex_src_a)   op_a = reg_c1_q;
    if (mem_fwd && mem_rd == ex_src_a) op_a = reg_c_q;
    if (b_is_r3(ex_op)) begin
      if (wb_fwd && wb_rd == ex_ir_q[2:0])   op_b = reg_c1_q;
      if (mem_fwd && mem_rd == ex_ir_q[2:0]) op_b = reg_c_q;
    end
    if (wb_fwd && wb_rd == ex_rd)   st_data = reg_c1_q;
    if (mem_fwd && mem_rd == ex_rd) st_data = reg_c_q;
  end
`else
  logic unused_ex_src_a;
  assign unused_ex_src_a = ^ex_src_a;
  assign stall = (writes_rd(ex_op) && reads_reg(id_ir_q, ex_rd)) ||
                 (writes_rd(mem_op) && reads_reg(id_ir_q, mem_rd));
  assign op_a    = reg_a_q;
  assign op_b    = reg_b_q;
  assign st_data = smdr_q;
`endif

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    case (ex_op)
      OP_ADD, OP_ADDI, OP_ADDC, OP_LDIH:
        {alu_cf, alu_res} = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, cf_q};
      OP_SUB, OP_SUBI, OP_SUBC, OP_CMP:
        {alu_cf, alu_res} = {1'b0, op_a} - {1'b0, op_b} - {{DATA_W{1'b0}}, cf_q};
      OP_AND:          alu_res = op_a & op_b;
      OP_OR:           alu_res = op_a | op_b;
      OP_XOR:          alu_res = op_a ^ op_b;
      OP_SLL, OP_SLA:  alu_res = op_a << op_b;
      OP_SRL:          alu_res = op_a >> op_b;
      OP_SRA:          alu_res = $signed(op_a) >>> op_b;
      OP_LOAD, OP_STORE, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
        alu_res = op_a + op_b;
      default:         alu_res = '0;
    endcase
  end

  always_comb begin
    case (ex_op)
      OP_JUMP, OP_JMPR: taken = 1'b1;
      OP_BZ:            taken = zf_q;
      OP_BNZ:           taken = !zf_q;
      OP_BN:            taken = nf_q;
      OP_BNN:           taken = !nf_q;
      OP_BC:            taken = cf_q;
      OP_BNC:           taken = !cf_q;
      default:          taken = 1'b0;
    endcase
    target = (ex_op == OP_JUMP) ? ADDR_W'(ex_ir_q[7:0]) : ADDR_W'(alu_res);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable && start) state_d = S_EXEC;
      S_EXEC: if (!enable || wb_op == OP_HALT) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;   id_ir_d = id_ir_q;
    ex_ir_d = ex_ir_q;   reg_a_d = reg_a_q;   reg_b_d = reg_b_q;   smdr_d = smdr_q;
    mem_ir_d = mem_ir_q; reg_c_d = reg_c_q;   smdr1_d = smdr1_q;
    wb_ir_d = wb_ir_q;   reg_c1_d = reg_c1_q;
    zf_d = zf_q;   nf_d = nf_q;   cf_d = cf_q;
    if (run) begin
      if (taken)      pc_d = target;
      else if (!stall) pc_d = pc_q + ADDR_W'(1);
      if (taken)      id_ir_d = '0;
      else if (!stall) id_ir_d = i_datain;
      ex_ir_d = (taken || stall) ? '0 : id_ir_q;
      reg_a_d = rd_a;
      smdr_d  = rd_s;
      if (b_is_r3(id_op))         reg_b_d = rd_b;
      else if (b_is_val3(id_op))  reg_b_d = DATA_W'(id_ir_q[3:0]);
      else if (id_op == OP_LDIH)  reg_b_d = DATA_W'({id_ir_q[7:0], 8'h00});
      else                        reg_b_d = DATA_W'(id_ir_q[7:0]);
      mem_ir_d = ex_ir_q;
      reg_c_d  = alu_res;
      smdr1_d  = st_data;
      wb_ir_d  = mem_ir_q;
      reg_c1_d = (mem_op == OP_LOAD) ? d_datain : reg_c_q;
      if (sets_flags(ex_op)) begin
        zf_d = (alu_res == '0);
        nf_d = alu_res[DATA_W-1];
        cf_d = alu_cf;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= ADDR_W'(RESET_PC);
      id_ir_q  <= '0;  ex_ir_q <= '0;  mem_ir_q <= '0;  wb_ir_q <= '0;
      reg_a_q  <= '0;  reg_b_q <= '0;  smdr_q   <= '0;
      reg_c_q  <= '0;  smdr1_q <= '0;  reg_c1_q <= '0;
      zf_q     <= 1'b0; nf_q   <= 1'b0; cf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      id_ir_q  <= id_ir_d;  ex_ir_q <= ex_ir_d;  mem_ir_q <= mem_ir_d;  wb_ir_q <= wb_ir_d;
      reg_a_q  <= reg_a_d;  reg_b_q <= reg_b_d;  smdr_q   <= smdr_d;
      reg_c_q  <= reg_c_d;  smdr1_q <= smdr1_d;  reg_c1_q <= reg_c1_d;
      zf_q     <= zf_d;     nf_q    <= nf_d;     cf_q     <= cf_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) gr_q[i] <= '0;
    end else if (wb_we) begin
      gr_q[wb_rd] <= reg_c1_q;
    end
  end

  assign i_addr    = pc_q;
  assign d_addr    = ADDR_W'(reg_c_q);
  assign d_dataout = smdr1_q;
  assign d_we      = run && (mem_op == OP_STORE);
  assign dbg_data  = gr_q[dbg_sel];
  assign busy      = (state_q == S_EXEC);

endmodule

// File: tb/tb_pipe_cpu_fwd.sv
// Directed bench for pipe_cpu_fwd: hazards, branch flush, store strobe, reset abort, enable freeze.
module tb_pipe_cpu_fwd;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam logic [4:0] NOP = 5'b00000, HALT = 5'b00001, LOAD = 5'b00010, STORE = 5'b00011;
  localparam logic [4:0] SRL = 5'b00110, SRA = 5'b00111, ADD = 5'b01000, ADDI = 5'b01001;
  localparam logic [4:0] SUB = 5'b01010, SUBI = 5'b01011, XOR = 5'b01111, LDIH = 5'b10000;
  localparam logic [4:0] BZ = 5'b11010, BC = 5'b11110;

`ifdef FORWARDING_EN
  localparam int CYC_T1 = 8, CYC_T2 = 8, CYC_T4 = 7;
`else
  localparam int CYC_T1 = 12, CYC_T2 = 9, CYC_T4 = 9;
`endif

  logic          clock = 1'b0, reset = 1'b0, enable = 1'b0, start = 1'b0;
  logic [2:0]    dbg_sel = '0;
  logic [AW-1:0] i_addr, d_addr;
  logic [15:0]   i_datain;
  logic [DW-1:0] d_datain, d_dataout, dbg_data;
  logic          d_we, busy;

  logic [15:0]   rom [256];
  logic [DW-1:0] ram [256];
  int            vectors = 0, miscompares = 0;
  int            cyc, we_cnt;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;
  logic [AW-1:0] trace [64];

  always #5 clock = ~clock;
  assign i_datain = rom[i_addr];
  assign d_datain = ram[d_addr];
  always @(posedge clock) if (d_we) ram[d_addr] <= d_dataout;

  pipe_cpu_fwd #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .i_addr(i_addr), .i_datain(i_datain), .d_addr(d_addr), .d_datain(d_datain),
    .d_dataout(d_dataout), .d_we(d_we), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                     input logic [3:0] v);
    return {op, rd, 1'b0, ra, v};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = {NOP, 11'd0};
      ram[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; start = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic run(input string tag);
    enable = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0; we_cnt = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc < 64) trace[cyc] = i_addr;
      if (d_we) begin
        we_cnt++; we_addr = d_addr; we_data = d_dataout;
      end
      @(posedge clock); #1;
    end
    chk({tag, "_halted"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic reg_is(input string tag, input logic [2:0] r, input logic [DW-1:0] exp);
    dbg_sel = r; #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    clear_mem();
    do_reset();
    chk("rst_pc", i_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dwe", d_we, 0);

    // 1: back-to-back dependency
    rom[0] = ri(ADDI, 1, 8'd5); rom[1] = rr(ADD, 2, 1, 1); rom[2] = rr(SUB, 3, 2, 1);
    rom[3] = {HALT, 11'd0};
    run("t1");
    chk("t1_cycles", cyc, CYC_T1);
    reg_is("t1_r1", 1, 16'd5);
    reg_is("t1_r2", 2, 16'd10);
    reg_is("t1_r3", 3, 16'd5);

    // 2: load-use
    clear_mem(); do_reset();
    ram[4] = 16'h00AA;
    rom[0] = rr(LOAD, 1, 0, 4); rom[1] = rr(ADD, 2, 1, 1); rom[2] = {HALT, 11'd0};
    run("t2");
    chk("t2_cycles", cyc, CYC_T2);
    reg_is("t2_r1", 1, 16'h00AA);
    reg_is("t2_r2", 2, 16'h0154);

    // 3: taken branch flushes two slots
    clear_mem(); do_reset();
    rom[0] = ri(SUBI, 1, 8'd0); rom[1] = ri(BZ, 0, 8'd8);
    rom[2] = ri(ADDI, 5, 8'd1); rom[3] = ri(ADDI, 6, 8'd1); rom[8] = {HALT, 11'd0};
    run("t3");
    chk("t3_cycles", cyc, 9);
    chk("t3_pc_c4", trace[4], 3);
    chk("t3_pc_c5", trace[5], 8);
    reg_is("t3_r5", 5, 16'd0);
    reg_is("t3_r6", 6, 16'd0);

    // 4: store after ALU
    clear_mem(); do_reset();
    rom[0] = ri(ADDI, 2, 8'd7); rom[1] = rr(STORE, 2, 0, 3); rom[2] = {HALT, 11'd0};
    run("t4");
    chk("t4_cycles", cyc, CYC_T4);
    chk("t4_we_cnt", we_cnt, 1);
    chk("t4_we_addr", we_addr, 3);
    chk("t4_we_data", we_data, 7);
    chk("t4_ram3", ram[3], 7);

    // 5: reset during the third cycle of program 1
    clear_mem(); do_reset();
    rom[0] = ri(ADDI, 1, 8'd5); rom[1] = rr(ADD, 2, 1, 1); rom[2] = rr(SUB, 3, 2, 1);
    rom[3] = {HALT, 11'd0};
    enable = 1'b1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("t5_pc_before", i_addr, 2);
    reset = 1'b0; #1;
    chk("t5_pc", i_addr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_dwe", d_we, 0);
    for (int r = 0; r < 8; r++) reg_is("t5_gr", 3'(r), 16'd0);
    @(negedge clock); reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("t5_pc_idle", i_addr, 0);
    chk("t5_busy_idle", busy, 0);
    reg_is("t5_r1_idle", 1, 16'd0);

    // 6a: write-first register read
    clear_mem(); do_reset();
    rom[0] = ri(ADDI, 4, 8'd9); rom[3] = rr(ADD, 3, 4, 4); rom[4] = {HALT, 11'd0};
    run("t6");
    chk("t6_cycles", cyc, 9);
    reg_is("t6_r4", 4, 16'd9);
    reg_is("t6_r3", 3, 16'd18);

    // 6b: enable drop freezes, re-start resumes
    clear_mem(); do_reset();
    for (int k = 0; k < 5; k++) rom[k] = ri(ADDI, 3'(k + 1), 8'(k + 1));
    rom[5] = {HALT, 11'd0};
    enable = 1'b1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    enable = 1'b0;
    @(posedge clock); #1;
    chk("t7_busy_off", busy, 0);
    chk("t7_pc_frozen", i_addr, 2);
    repeat (3) @(posedge clock);
    #1;
    chk("t7_pc_still", i_addr, 2);
    run("t7");
    chk("t7_cycles", cyc, 8);
    for (int k = 1; k <= 5; k++) reg_is("t7_rk", 3'(k), DW'(k));

    // 8: shifts, logic, borrow and branch on carry
    clear_mem(); do_reset();
    rom[0] = ri(LDIH, 1, 8'h80);  rom[1] = rr(SRA, 2, 1, 3);  rom[2] = rr(SRL, 3, 1, 3);
    rom[3] = rr(XOR, 4, 2, 3);    rom[4] = rr(SUB, 5, 3, 2);  rom[5] = ri(BC, 0, 8'd8);
    rom[6] = ri(ADDI, 6, 8'd1);   rom[7] = ri(ADDI, 6, 8'd1); rom[8] = rr(ADD, 7, 0, 0);
    rom[9] = {HALT, 11'd0};
    run("t8");
    reg_is("t8_r1", 1, 16'h8000);
    reg_is("t8_r2", 2, 16'hF000);
    reg_is("t8_r3", 3, 16'h1000);
    reg_is("t8_r4", 4, 16'hE000);
    reg_is("t8_r5", 5, 16'h2000);
    reg_is("t8_r6", 6, 16'h0000);
    reg_is("t8_r7", 7, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
